// File: rtl/pi_action_servo.sv
// PI loop filter: signed phase error in, clamped signed ACTION word out (fixed latency 2).
// Integrator is clamped (anti-windup); state reports IDLE / TRACK / RAILED.
module pi_action_servo #(
  parameter int ERR_W    = 16,
  parameter int ACT_W    = 32,
  parameter int KP_SHIFT = 8,
  parameter int KI_SHIFT = 2,
  parameter int ACT_MAX  = 2**30-1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic                    err_valid,
  input  logic signed [ERR_W-1:0] err,
  output logic                    action_valid,
  output logic signed [ACT_W-1:0] action,
  output logic                    railed,
  output logic [1:0]              state
);
  // Two guard bits so P + I never wraps before clamping.
  localparam int IW = ACT_W + 2;
  typedef logic signed [IW-1:0] acc_t;
  localparam acc_t MAXV = acc_t'(ACT_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, RAILED = 2'd2} st_t;

  function automatic acc_t clamp(input acc_t v);
    if (v > MAXV)       return MAXV;
    else if (v < -MAXV) return -MAXV;
    return v;
  endfunction

  st_t        st;
  logic [1:0] vld_pipe;
  acc_t       p_r, i_acc;
  acc_t       err_x, p_term, i_next, a_sum, a_clamp;
  logic       a_rail;

  always_comb begin
    err_x   = {{(IW-ERR_W){err[ERR_W-1]}}, err};
    p_term  = err_x <<< KP_SHIFT;
    i_next  = clamp(i_acc + (err_x <<< KI_SHIFT));
    // i_acc already holds I_next of the sample sitting in stage 1.
    a_sum   = p_r + i_acc;
    a_clamp = clamp(a_sum);
    a_rail  = (a_sum != a_clamp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      vld_pipe <= '0;
      p_r      <= '0;
      i_acc    <= '0;
      action   <= '0;
      railed   <= 1'b0;
    end else if (!en || clear) begin
      // Flush and zero; clear keeps the loop in TRACK, en=0 parks it.
      st       <= en ? TRACK : IDLE;
      vld_pipe <= '0;
      p_r      <= '0;
      i_acc    <= '0;
      action   <= '0;
      railed   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], err_valid};
      if (err_valid) begin
        p_r   <= p_term;
        i_acc <= i_next;
      end
      if (vld_pipe[0]) begin
        action <= ACT_W'(a_clamp);
        railed <= a_rail;
        st     <= a_rail ? RAILED : TRACK;
      end else if (st == IDLE) begin
        st <= TRACK;
      end
    end
  end

  assign action_valid = vld_pipe[1];
  assign state        = st;
endmodule
